// File: rtl/rgb_seq_pkg.sv
// Shared types and widths for the RGB block sequencer and its coefficient serializer.
package rgb_seq_pkg;

    typedef enum logic [1:0] {FILL, START, WAIT, DRAIN} state_t;

    localparam int PIXEL_BITS   = 8;
    localparam int COEF_BITS    = 16;
    localparam int BLOCK_PIXELS = 64;
    localparam int IDX_BITS     = 6;

    localparam int RGB_BUS_BITS = PIXEL_BITS * BLOCK_PIXELS;
    localparam int Y_BUS_BITS   = COEF_BITS * BLOCK_PIXELS;

endpackage

// File: rtl/coef_serializer.sv
// Captures the 1024-bit conversion result and streams it out as 64 16-bit words over valid/ready.
module coef_serializer
    import rgb_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [Y_BUS_BITS-1:0] y_in,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [COEF_BITS-1:0]  m_data,
    output logic                  m_last,
    output logic                  done
);

    logic [Y_BUS_BITS-1:0] y_q, y_d;
    logic [IDX_BITS-1:0]   out_idx_q, out_idx_d;
    logic                  m_valid_q, m_valid_d;
    logic                  last_word;

    assign last_word = (out_idx_q == IDX_BITS'(BLOCK_PIXELS - 1));

    always_comb begin
        y_d       = y_q;
        out_idx_d = out_idx_q;
        m_valid_d = m_valid_q;
        done      = 1'b0;
        if (load) begin
            y_d       = y_in;
            out_idx_d = '0;
            m_valid_d = 1'b1;
        end else if (m_valid_q && m_ready) begin
            if (last_word) begin
                out_idx_d = '0;
                m_valid_d = 1'b0;
                done      = 1'b1;
            end else begin
                out_idx_d = out_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= '0;
            out_idx_q <= '0;
            m_valid_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            out_idx_q <= out_idx_d;
            m_valid_q <= m_valid_d;
        end
    end

    // Word select is driven purely by registers, so m_data holds still during a stall.
    assign m_valid = m_valid_q;
    assign m_data  = y_q[{out_idx_q, 4'b0000} +: COEF_BITS];
    assign m_last  = m_valid_q && last_word;

endmodule

// File: rtl/rgb_block_sequencer.sv
// Packs a 64-pixel RGB raster into R/G/B buses, kicks the conversion block, waits with a
// timeout for finished, then hands the captured Y result to the serializer.
module rgb_block_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int PIXEL_COUNT = 64,
    parameter int WAIT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [PIXEL_BITS-1:0]   s_r,
    input  logic [PIXEL_BITS-1:0]   s_g,
    input  logic [PIXEL_BITS-1:0]   s_b,
    output logic                    start,
    output logic [RGB_BUS_BITS-1:0] R,
    output logic [RGB_BUS_BITS-1:0] G,
    output logic [RGB_BUS_BITS-1:0] B,
    input  logic [Y_BUS_BITS-1:0]   Y_in,
    input  logic                    finished,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [COEF_BITS-1:0]    m_data,
    output logic                    m_last,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t                  state_q, state_d;
    logic [IDX_BITS-1:0]     pix_idx_q, pix_idx_d;
    logic [WCW-1:0]          wait_cnt_q, wait_cnt_d;
    logic [RGB_BUS_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic                    start_q, start_d;
    logic                    s_ready_q, s_ready_d;
    logic                    busy_q, busy_d;
    logic                    timeout_q, timeout_d;
    logic                    load;
    logic                    drain_done;

    always_comb begin
        state_d    = state_q;
        pix_idx_d  = pix_idx_q;
        wait_cnt_d = wait_cnt_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        timeout_d  = timeout_q;
        load       = 1'b0;
        case (state_q)
            FILL: begin
                if (s_valid && s_ready_q) begin
                    r_d[{pix_idx_q, 3'b000} +: PIXEL_BITS] = s_r;
                    g_d[{pix_idx_q, 3'b000} +: PIXEL_BITS] = s_g;
                    b_d[{pix_idx_q, 3'b000} +: PIXEL_BITS] = s_b;
                    if (pix_idx_q == IDX_BITS'(PIXEL_COUNT - 1)) begin
                        pix_idx_d = '0;
                        state_d   = START;
                    end else begin
                        pix_idx_d = pix_idx_q + 1'b1;
                    end
                end
            end
            START: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // The first WAIT cycle ignores finished: it may still be high from the last block.
                if (finished && (wait_cnt_q != '0)) begin
                    load    = 1'b1;
                    state_d = DRAIN;
                end else if (wait_cnt_q == WCW'(WAIT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    load      = 1'b1;
                    state_d   = DRAIN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    wait_cnt_d = '0;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        start_d   = (state_d == START);
        s_ready_d = (state_d == FILL);
        busy_d    = (state_d != FILL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            pix_idx_q  <= '0;
            wait_cnt_q <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            start_q    <= 1'b0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_idx_q  <= pix_idx_d;
            wait_cnt_q <= wait_cnt_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            start_q    <= start_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    coef_serializer u_serializer (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .y_in    (Y_in),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .done    (drain_done)
    );

    assign s_ready     = s_ready_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_q;
    assign R           = r_q;
    assign G           = g_q;
    assign B           = b_q;

endmodule

// File: tb/tb_rgb_block_sequencer.sv
// Directed bench for rgb_block_sequencer; WAIT_CYCLES shortened to 16 so timeouts are reachable.
`timescale 1ns/1ps
module tb_rgb_block_sequencer;

    localparam int WAIT_CYCLES = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [7:0]     s_r = '0, s_g = '0, s_b = '0;
    logic           start;
    logic [511:0]   R, G, B;
    logic [1023:0]  Y_in = '0;
    logic           finished = 1'b0;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [15:0]    m_data;
    logic           m_last;
    logic           busy;
    logic           timeout_err;

    int tests = 0;
    int fails = 0;
    int start_count = 0;

    rgb_block_sequencer #(.PIXEL_COUNT(64), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_r(s_r), .s_g(s_g), .s_b(s_b), .start(start),
        .R(R), .G(G), .B(B), .Y_in(Y_in), .finished(finished),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (start === 1'b1) start_count++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_y(input logic [15:0] base);
        for (int i = 0; i < 64; i++) Y_in[i*16 +: 16] = base + 16'(i);
    endtask

    // Streams 64 pixels (r=roff+k, g=0x80+k, b=0xFF-k); returns at the negedge after the 64th handshake.
    task automatic fill_block(input logic [7:0] roff, input bit keep);
        int k = 0;
        int guard = 0;
        bit hs;
        while (k < 64 && guard < 2000) begin
            s_valid = 1'b1;
            s_r = roff + 8'(k);
            s_g = 8'h80 + 8'(k);
            s_b = 8'hFF - 8'(k);
            hs = s_ready;
            @(negedge clk);
            if (hs) k++;
            guard++;
        end
        if (!keep) s_valid = 1'b0;
        tests++;
        if (k != 64) begin fails++; $display("[TB] FAIL fill_handshakes: got %0d expected 64", k); end
    endtask

    task automatic drain_block(input logic [15:0] base, output int words, output int bad);
        int guard = 0;
        words = 0;
        bad = 0;
        m_ready = 1'b1;
        while (words < 64 && guard < 1000) begin
            if (m_valid) begin
                if (m_data !== base + 16'(words)) bad++;
                if (m_last !== (words == 63)) bad++;
                words++;
            end
            @(negedge clk);
            guard++;
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (s_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_s_ready: got %b expected 0", s_ready); end
        tests++; if (start !== 1'b0) begin fails++; $display("[TB] FAIL reset_start: got %b expected 0", start); end
        tests++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_valid_last: got %b%b expected 00", m_valid, m_last); end
        tests++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy_timeout: got %b%b expected 00", busy, timeout_err); end
        tests++; if (R !== '0 || G !== '0 || B !== '0) begin fails++; $display("[TB] FAIL reset_rgb: got R[31:0]=%h expected 0", R[31:0]); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (s_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_release_s_ready: got %b expected 1", s_ready); end
    endtask

    task automatic test_fill();
        int words, bad;
        finished = 1'b0; m_ready = 1'b0; set_y(16'h2000);
        fill_block(8'h00, 1'b0);
        tests++; if (start !== 1'b1) begin fails++; $display("[TB] FAIL fill_start_pulse: got %b expected 1", start); end
        tests++; if (s_ready !== 1'b0) begin fails++; $display("[TB] FAIL fill_s_ready_drop: got %b expected 0", s_ready); end
        tests++; if (R[7:0] !== 8'h00) begin fails++; $display("[TB] FAIL fill_r0: got %h expected 00", R[7:0]); end
        tests++; if (R[511:504] !== 8'h3F) begin fails++; $display("[TB] FAIL fill_r63: got %h expected 3f", R[511:504]); end
        tests++; if (B[511:504] !== 8'hC0) begin fails++; $display("[TB] FAIL fill_b63: got %h expected c0", B[511:504]); end
        tests++; if (G[15:8] !== 8'h81) begin fails++; $display("[TB] FAIL fill_g1: got %h expected 81", G[15:8]); end
        @(negedge clk);
        tests++; if (start !== 1'b0 || busy !== 1'b1) begin fails++; $display("[TB] FAIL fill_start_width: got start=%b busy=%b expected 0 1", start, busy); end
        repeat (4) @(negedge clk);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL fill_no_early_valid: got %b expected 0", m_valid); end
        finished = 1'b1;
        @(negedge clk);
        tests++; if (m_valid !== 1'b1 || m_data !== 16'h2000) begin fails++; $display("[TB] FAIL fill_first_word: got v=%b d=%h expected 1 2000", m_valid, m_data); end
        finished = 1'b0;
        drain_block(16'h2000, words, bad);
        tests++; if (words != 64 || bad != 0) begin fails++; $display("[TB] FAIL fill_drain: got words=%0d bad=%0d expected 64 0", words, bad); end
        tests++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL fill_end_state: got busy=%b to=%b expected 0 0", busy, timeout_err); end
    endtask

    task automatic test_stale_finished();
        int words, bad;
        finished = 1'b1; m_ready = 1'b0; set_y(16'h1000);
        fill_block(8'h10, 1'b0);
        @(negedge clk);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL stale_wait0: got %b expected 0", m_valid); end
        @(negedge clk);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL stale_no_capture_first_wait: got %b expected 0", m_valid); end
        @(negedge clk);
        tests++; if (m_valid !== 1'b1) begin fails++; $display("[TB] FAIL stale_capture_second_wait: got %b expected 1", m_valid); end
        drain_block(16'h1000, words, bad);
        finished = 1'b0;
        tests++; if (words != 64 || bad != 0) begin fails++; $display("[TB] FAIL stale_sequence: got words=%0d bad=%0d expected 64 0", words, bad); end
    endtask

    task automatic test_backpressure();
        int idx = 0, cycles = 0, bad = 0, guard = 0;
        finished = 1'b1; m_ready = 1'b0; set_y(16'h3000);
        fill_block(8'h20, 1'b0);
        while (!m_valid && guard < 50) begin @(negedge clk); guard++; end
        finished = 1'b0;
        while (idx < 64 && cycles < 300) begin
            m_ready = (cycles % 2 == 0);
            if (m_valid !== 1'b1) bad++;
            if (m_data !== 16'h3000 + 16'(idx)) bad++;
            if (m_ready) idx++;
            cycles++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        tests++; if (idx != 64 || cycles != 127) begin fails++; $display("[TB] FAIL bp_count: got words=%0d cycles=%0d expected 64 127", idx, cycles); end
        tests++; if (bad != 0) begin fails++; $display("[TB] FAIL bp_data_stable: got %0d bad samples expected 0", bad); end
        tests++; if (busy !== 1'b0 || m_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_end: got busy=%b v=%b expected 0 0", busy, m_valid); end
    endtask

    task automatic test_finish_at_boundary();
        int words, bad;
        finished = 1'b0; set_y(16'h4000);
        fill_block(8'h30, 1'b0);
        repeat (16) @(negedge clk);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL boundary_no_early: got %b expected 0", m_valid); end
        finished = 1'b1;
        @(negedge clk);
        tests++; if (m_valid !== 1'b1 || timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL boundary_finish_wins: got v=%b to=%b expected 1 0", m_valid, timeout_err); end
        finished = 1'b0;
        drain_block(16'h4000, words, bad);
        tests++; if (words != 64 || bad != 0) begin fails++; $display("[TB] FAIL boundary_drain: got words=%0d bad=%0d expected 64 0", words, bad); end
    endtask

    task automatic test_timeout();
        int words, bad;
        finished = 1'b0; set_y(16'h5000);
        fill_block(8'h50, 1'b0);
        repeat (16) @(negedge clk);
        tests++; if (timeout_err !== 1'b0 || m_valid !== 1'b0) begin fails++; $display("[TB] FAIL timeout_early: got to=%b v=%b expected 0 0", timeout_err, m_valid); end
        @(negedge clk);
        tests++; if (timeout_err !== 1'b1 || m_valid !== 1'b1) begin fails++; $display("[TB] FAIL timeout_set: got to=%b v=%b expected 1 1", timeout_err, m_valid); end
        drain_block(16'h5000, words, bad);
        tests++; if (words != 64 || bad != 0) begin fails++; $display("[TB] FAIL timeout_drain: got words=%0d bad=%0d expected 64 0", words, bad); end
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("[TB] FAIL timeout_sticky: got %b expected 1", timeout_err); end
    endtask

    task automatic test_back_to_back();
        int low = 0, vcnt = 0, guard = 0, first;
        finished = 1'b1; m_ready = 1'b1; set_y(16'h6000);
        first = start_count;
        fill_block(8'h40, 1'b1);
        while (!s_ready && guard < 200) begin
            if (m_valid) vcnt++;
            low++; guard++;
            @(negedge clk);
        end
        tests++; if (low != 67 || vcnt != 64) begin fails++; $display("[TB] FAIL b2b_ready_low: got low=%0d words=%0d expected 67 64", low, vcnt); end
        fill_block(8'hA0, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        tests++; if (R[7:0] !== 8'hA0 || R[511:504] !== 8'hDF) begin fails++; $display("[TB] FAIL b2b_second_block: got %h %h expected a0 df", R[7:0], R[511:504]); end
        tests++; if (start_count - first != 2) begin fails++; $display("[TB] FAIL b2b_start_count: got %0d expected 2", start_count - first); end
        guard = 0;
        while (!s_ready && guard < 200) begin @(negedge clk); guard++; end
        tests++; if (s_ready !== 1'b1 || timeout_err !== 1'b1) begin fails++; $display("[TB] FAIL b2b_end: got rdy=%b to=%b expected 1 1", s_ready, timeout_err); end
        m_ready = 1'b0; finished = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        int guard = 0;
        finished = 1'b1; m_ready = 1'b0; set_y(16'h1000);
        fill_block(8'h00, 1'b0);
        while (!m_valid && guard < 50) begin @(negedge clk); guard++; end
        m_ready = 1'b1;
        repeat (20) @(negedge clk);
        m_ready = 1'b0;
        tests++; if (m_data !== 16'h1014 || m_valid !== 1'b1) begin fails++; $display("[TB] FAIL mid_drain_word20: got v=%b d=%h expected 1 1014", m_valid, m_data); end
        #2 rst = 1'b1;
        #1;
        tests++; if (m_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL mid_drain_async: got v=%b busy=%b expected 0 0", m_valid, busy); end
        tests++; if (timeout_err !== 1'b0 || s_ready !== 1'b0) begin fails++; $display("[TB] FAIL mid_drain_clear: got to=%b rdy=%b expected 0 0", timeout_err, s_ready); end
        @(negedge clk);
        rst = 1'b0; finished = 1'b0;
        @(negedge clk);
        tests++; if (s_ready !== 1'b1 || R !== '0) begin fails++; $display("[TB] FAIL mid_drain_after: got rdy=%b R[31:0]=%h expected 1 0", s_ready, R[31:0]); end
        tests++; if (m_data !== 16'h0000 || m_last !== 1'b0) begin fails++; $display("[TB] FAIL mid_drain_y_cleared: got d=%h last=%b expected 0000 0", m_data, m_last); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stale_finished();
        test_backpressure();
        test_finish_at_boundary();
        test_timeout();
        test_back_to_back();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rgb_block_sequencer.md
Name: rgb_block_sequencer

Overview:
- Hardware initiator for the colour-conversion block interface: the on-chip replacement for the bench-side driver.
- Collects a raster stream of 64 RGB pixels into 512-bit R/G/B buses and issues a one-cycle start.
- Waits for finished, with a timeout, then captures the 1024-bit Y result.
- Streams the result out as 64 16-bit words over valid/ready.

Parameters:
- PIXEL_COUNT, 64, pixels per 8x8 block; fixed at 64 for bus widths.
- WAIT_CYCLES, 1000000, maximum WAIT cycles before timeout.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid&&s_ready.
- s_r, s_g, s_b  in  8 each  input pixel components.
- start  out  1  one-cycle start pulse to the conversion block.
- R, G, B  out  512 each  assembled block; pixel i at [i*8 +: 8].
- Y_in  in  1024  conversion result; word i at [i*16 +: 16].
- finished  in  1  conversion complete (level).
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream ready.
- m_data  out  16  output word.
- m_last  out  1  high with word 63.
- busy  out  1  high in any state other than FILL.
- timeout_err  out  1  sticky; set on timeout.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=FILL; pix_idx=0, out_idx=0, wait_cnt=0.
  - R/G/B=0, Y capture register=0.
  - start=0, s_ready=0 during reset, m_valid=0, m_last=0, busy=0, timeout_err=0.
- FILL:
  - s_ready=1.
  - On handshake: store s_r/s_g/s_b at pixel pix_idx and increment pix_idx.
  - On the handshake with pix_idx==63: pix_idx wraps to 0; go to START next cycle.
  - No partial-block flush.
- START:
  - s_ready=0; start=1 for exactly this cycle; go to WAIT.
  - R/G/B are held stable from entry to START until return to FILL.
- WAIT:
  - wait_cnt increments each cycle from 0.
  - finished is ignored while wait_cnt==0, which masks a stale level from the previous block.
  - If finished=1 and wait_cnt>=1: capture Y_in, go to DRAIN.
  - Else if wait_cnt==WAIT_CYCLES-1: set timeout_err=1, capture Y_in as is, go to DRAIN.
  - If finished arrives on the same cycle as the timeout boundary, finished wins and timeout_err is not set.
- DRAIN:
  - m_valid=1; m_data=Y[out_idx*16 +: 16]; m_last=(out_idx==63).
  - m_data is stable while m_valid&&!m_ready.
  - Each handshake increments out_idx.
  - On the last handshake: out_idx=0, wait_cnt=0, go to FILL. s_ready rises the following cycle.
- Latency:
  - Last input handshake to start: 1 cycle.
  - finished seen to first m_valid: 1 cycle.
  - Best-case output: 64 cycles with m_ready held high.
- timeout_err clears only on reset.
- Widths: pix_idx and out_idx are 6 bits; wait_cnt is $clog2(WAIT_CYCLES) bits. No arithmetic on data; pure packing and unpacking.

Decomposition:
- Package rgb_seq_pkg:
  - state enum {FILL, START, WAIT, DRAIN}.
  - PIXEL_BITS=8, COEF_BITS=16, BLOCK_PIXELS=64.
  - Bus width constants 512/1024.
- Sub-module coef_serializer: 1024-bit capture register plus out_idx, m_valid/m_data/m_last and the handshake.
  - Inputs: load pulse, Y_in, m_ready.
  - Output: done pulse.
- Top holds the FSM, the pixel packer and the wait counter.

Test Plan:
- Reset mid-DRAIN: assert rst at out_idx=20 -> m_valid=0, busy=0 in the same cycle. After release, s_ready=1 and R=0.
- Fill with pixel i = (r=i, g=0x80+i, b=0xFF-i), s_valid held high, then finished 5 cycles after start:
  - R[7:0]=0x00, R[511:504]=0x3F, B[511:504]=0xC0.
  - start high exactly 1 cycle, 1 cycle after the 64th handshake.
- Stale finished held high before start:
  - No capture in the first WAIT cycle; capture on the second.
  - Model Y_in word i = 0x1000+i -> m_data sequence 0x1000..0x103F, m_last only on 0x103F.
- Output backpressure: m_ready toggles 1-0 every cycle -> m_data stable during stalls; 64 words in 127 cycles with no drops or duplicates.
- Timeout with WAIT_CYCLES=16 and finished never asserted:
  - timeout_err=1 after 16 WAIT cycles, 64 words drained.
  - timeout_err stays 1 through the next block.
- Back-to-back blocks: two blocks streamed with s_valid held high -> s_ready=0 from START through the end of DRAIN. The second block's first pixel lands at R[7:0], and the start count is 2.
